pim_bus_target: RTL and testbench
=================================

Name: pim_bus_target

Overview:
- Memory-side responder on the shared PIM bus; it answers the transactions that the bus initiator drives.
- Decodes bus address, write enable and write data.
- Stores words in a local DEPTH-word array.
- Returns read data with a fixed, parameterised latency.
- A secondary core read port lets the PIM compute side read the same array.

Parameters:
- BUS_WIDTH_BITS, 64, data word width; must be a multiple of 8.
- ADDR_WIDTH_BITS, 64, bus byte-address width.
- DEPTH, 256, number of words in the array; power of 2, at least 2.
- BASE_ADDR, 0, byte address of word 0; must be aligned to BUS_WIDTH_BITS/8.
- READ_LATENCY, 2, cycles from accepted read to bus_read_valid; must be at least 1.
- ERR_DATA, {BUS_WIDTH_BITS/32{32'hDEADBEEF}}, data returned for out-of-range reads.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- bus_sel, in, 1: target selected; this is the initiator's bus_grant.
- bus_addr, in, ADDR_WIDTH_BITS: byte address.
- bus_write_en, in, 1: write beat.
- bus_write_data, in, BUS_WIDTH_BITS: write data.
- bus_read_data, out, BUS_WIDTH_BITS: read data.
- bus_read_valid, out, 1: read data valid, one-cycle pulse.
- core_rd_en, in, 1: core-side read request.
- core_rd_addr, in, $clog2(DEPTH): core word index.
- core_rd_data, out, BUS_WIDTH_BITS: core read data.
- core_rd_valid, out, 1: core read data valid.
- err_pulse, out, 1: one-cycle error flag.
- rd_count, out, 32: accepted bus reads (see optional feature).
- wr_count, out, 32: performed bus writes (see optional feature).

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous and active-low. All outputs reset to 0, the FSM resets to IDLE, and the latency counter resets to 0. Array contents are not reset.
- Decode:
  - off = bus_addr - BASE_ADDR, computed at ADDR_WIDTH_BITS width.
  - idx = off >> log2(BUS_WIDTH_BITS/8); low byte-offset bits are ignored.
  - In range iff bus_addr >= BASE_ADDR and idx < DEPTH.
- FSM states are IDLE, READ_WAIT and RESPOND.
- IDLE, write beat (bus_sel=1, bus_write_en=1):
  - In range: array[idx] <= bus_write_data at this edge.
  - Out of range: the write is dropped and err_pulse=1 next cycle.
  - The state stays IDLE. Back-to-back writes are accepted every cycle.
- IDLE, read request (bus_sel=1, bus_write_en=0):
  - Capture the array word, or ERR_DATA if out of range, into the data pipe. Set cnt = READ_LATENCY-1.
  - If cnt == 0, go to RESPOND; otherwise go to READ_WAIT.
  - An out-of-range read also raises err_pulse=1 in the next cycle.
- READ_WAIT:
  - Decrement cnt each cycle; go to RESPOND when cnt reaches 1.
  - The held bus_sel/bus_addr are ignored. The initiator stalls with a stable address, so this is not a new request.
- RESPOND:
  - bus_read_valid=1 and bus_read_data = captured word for exactly one cycle.
  - Next state is IDLE unconditionally.
  - bus_read_data holds its last value when valid is low.
- Timing: a read accepted at edge k gives bus_read_valid high in the cycle between edges k+READ_LATENCY and k+READ_LATENCY+1. Consecutive reads are therefore spaced READ_LATENCY+1 cycles apart.
- A write beat seen in READ_WAIT or RESPOND is a protocol violation: it is dropped and err_pulse=1.
- Data capture happens at acceptance. A core-side array change during READ_WAIT does not alter the returned data.
- Core port:
  - core_rd_data = array[core_rd_addr] and core_rd_valid=1 one cycle after core_rd_en.
  - It operates independently of the bus FSM.
  - If a bus write to the same index occurs at the same edge, core_rd_data returns the old (pre-write) value.
- Reset mid-read aborts the read: no bus_read_valid is issued and the FSM is in IDLE.

Optional Feature:
- Macro: PIM_BUS_TARGET_STATS_EN.
- Defined:
  - rd_count increments on each accepted bus read; wr_count increments on each performed in-range bus write.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: rd_count and wr_count are tied to 0 and no counter flops exist.

Test Plan:
- Write 0x1111_2222_3333_4444 to BASE_ADDR+8, then read BASE_ADDR+8 with READ_LATENCY=2 -> read accepted at edge k, bus_read_valid high in the cycle after edge k+2 with that data; held request produces no second pulse.
- 4 back-to-back write beats to addresses 0x0, 0x8, 0x10, 0x18 (data 1..4), then a 4-beat read burst with the initiator stalling -> valid pulses return 1,2,3,4 spaced 3 cycles apart.
- Read at BASE_ADDR+DEPTH*8 -> data 0xDEADBEEFDEADBEEF and err_pulse high for 1 cycle; write to the same address -> dropped, err_pulse=1, array unchanged.
- Read of BASE_ADDR+0xC (unaligned) -> returns word 1.
- core_rd_en with core_rd_addr=3 at the same edge as a bus write to idx 3 -> core_rd_data = old value, core_rd_valid=1 one cycle later; a read the next cycle returns the new value.
- rst_n asserted during READ_WAIT -> bus_read_valid stays 0 and outputs are 0. With PIM_BUS_TARGET_STATS_EN, 3 writes + 2 reads -> wr_count=3, rd_count=2; the counters clear on reset.

Source files
------------

// File: rtl/pim_bus_target.sv
// PIM bus memory-side target: decodes bus reads/writes into a local word array,
// answers reads after READ_LATENCY cycles, and has an independent core read port.
// Optional access counters: define PIM_BUS_TARGET_STATS_EN.
module pim_bus_target #(
  parameter int                          BUS_WIDTH_BITS  = 64,
  parameter int                          ADDR_WIDTH_BITS = 64,
  parameter int                          DEPTH           = 256,
  parameter logic [ADDR_WIDTH_BITS-1:0]  BASE_ADDR       = '0,
  parameter int                          READ_LATENCY    = 2,
  parameter logic [BUS_WIDTH_BITS-1:0]   ERR_DATA        = {BUS_WIDTH_BITS/32{32'hDEADBEEF}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bus_sel,
  input  logic [ADDR_WIDTH_BITS-1:0]  bus_addr,
  input  logic                        bus_write_en,
  input  logic [BUS_WIDTH_BITS-1:0]   bus_write_data,
  output logic [BUS_WIDTH_BITS-1:0]   bus_read_data,
  output logic                        bus_read_valid,
  input  logic                        core_rd_en,
  input  logic [$clog2(DEPTH)-1:0]    core_rd_addr,
  output logic [BUS_WIDTH_BITS-1:0]   core_rd_data,
  output logic                        core_rd_valid,
  output logic                        err_pulse,
  output logic [31:0]                 rd_count,
  output logic [31:0]                 wr_count
);

  localparam int IDX_W      = $clog2(DEPTH);
  localparam int BYTE_SHIFT = $clog2(BUS_WIDTH_BITS / 8);
  localparam int CNT_W      = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESPOND
  } state_t;

  state_t                     state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;

  logic [BUS_WIDTH_BITS-1:0]  mem [DEPTH];
  logic [BUS_WIDTH_BITS-1:0]  rd_word_reg;
  logic                       rd_err_reg;

  logic [BUS_WIDTH_BITS-1:0]  bus_read_data_reg;
  logic                       bus_read_valid_reg;
  logic [BUS_WIDTH_BITS-1:0]  core_rd_data_reg;
  logic                       core_rd_valid_reg;
  logic                       err_pulse_reg;

  logic [ADDR_WIDTH_BITS-1:0] off;
  logic [IDX_W-1:0]           idx;
  logic                       in_range;

  logic                       accept_read;
  logic                       do_write;
  logic                       err_next;
  logic                       respond;

  // Byte offset bits below the word size are simply dropped.
  assign off      = bus_addr - BASE_ADDR;
  assign idx      = off[BYTE_SHIFT +: IDX_W];
  assign in_range = (bus_addr >= BASE_ADDR) &&
                    ((off >> BYTE_SHIFT) < ADDR_WIDTH_BITS'(DEPTH));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept_read = 1'b0;
    do_write    = 1'b0;
    err_next    = 1'b0;
    respond     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus_sel) begin
          if (bus_write_en) begin
            do_write = in_range;
            err_next = !in_range;
          end else begin
            accept_read = 1'b1;
            err_next    = !in_range;
            cnt_next    = CNT_INIT;
            state_next  = (CNT_INIT == '0) ? RESPOND : READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        // The initiator keeps its request asserted while stalled; only writes matter here.
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = RESPOND;
        end
        if (bus_sel && bus_write_en) begin
          err_next = 1'b1;
        end
      end
      RESPOND: begin
        respond    = 1'b1;
        state_next = IDLE;
        if (bus_sel && bus_write_en) begin
          err_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      rd_err_reg         <= 1'b0;
      bus_read_data_reg  <= '0;
      bus_read_valid_reg <= 1'b0;
      err_pulse_reg      <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      bus_read_valid_reg <= respond;
      err_pulse_reg      <= err_next;
      if (accept_read) begin
        rd_err_reg <= !in_range;
      end
      if (respond) begin
        bus_read_data_reg <= rd_err_reg ? ERR_DATA : rd_word_reg;
      end
    end
  end

  // Array and read capture carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= bus_write_data;
    end
    if (accept_read) begin
      rd_word_reg <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rd_data_reg  <= '0;
      core_rd_valid_reg <= 1'b0;
    end else begin
      core_rd_valid_reg <= core_rd_en;
      if (core_rd_en) begin
        core_rd_data_reg <= mem[core_rd_addr];
      end
    end
  end

  assign bus_read_data  = bus_read_data_reg;
  assign bus_read_valid = bus_read_valid_reg;
  assign core_rd_data   = core_rd_data_reg;
  assign core_rd_valid  = core_rd_valid_reg;
  assign err_pulse      = err_pulse_reg;

`ifdef PIM_BUS_TARGET_STATS_EN
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (accept_read && (rd_count_reg != 32'hFFFF_FFFF)) begin
        rd_count_reg <= rd_count_reg + 32'd1;
      end
      if (do_write && (wr_count_reg != 32'hFFFF_FFFF)) begin
        wr_count_reg <= wr_count_reg + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_pim_bus_target.sv
// Scoreboard bench for pim_bus_target: expected read words are queued at acceptance
// and compared (data and latency) whenever bus_read_valid pulses.
module tb_pim_bus_target;

  localparam int          DEPTH = 256;
  localparam int          RL    = 2;
  localparam logic [63:0] BASE  = 64'h0;
  localparam logic [63:0] ERRW  = 64'hDEADBEEF_DEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_sel = 1'b0;
  logic [63:0] bus_addr = '0;
  logic        bus_write_en = 1'b0;
  logic [63:0] bus_write_data = '0;
  logic [63:0] bus_read_data;
  logic        bus_read_valid;
  logic        core_rd_en = 1'b0;
  logic [7:0]  core_rd_addr = '0;
  logic [63:0] core_rd_data;
  logic        core_rd_valid;
  logic        err_pulse;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  pim_bus_target #(
    .BUS_WIDTH_BITS (64),
    .ADDR_WIDTH_BITS(64),
    .DEPTH          (DEPTH),
    .BASE_ADDR      (BASE),
    .READ_LATENCY   (RL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_sel       (bus_sel),
    .bus_addr      (bus_addr),
    .bus_write_en  (bus_write_en),
    .bus_write_data(bus_write_data),
    .bus_read_data (bus_read_data),
    .bus_read_valid(bus_read_valid),
    .core_rd_en    (core_rd_en),
    .core_rd_addr  (core_rd_addr),
    .core_rd_data  (core_rd_data),
    .core_rd_valid (core_rd_valid),
    .err_pulse     (err_pulse),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [DEPTH];
  int checks = 0, errors = 0, cyc = 0, n_pulses = 0, n_reads = 0, m_rd = 0, m_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
  endfunction

  function automatic logic [7:0] widx(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) >> 3;
    return o[7:0];
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus_read_valid) begin
      n_pulses++;
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", bus_read_data, e.data);
        chk("rd_latency", 64'(cyc), 64'(e.due));
        $display("read  data=%h at cycle %0d", bus_read_data, cyc);
      end
    end
  end

  task automatic idle();
    bus_sel      = 1'b0;
    bus_write_en = 1'b0;
  endtask

  task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
    bus_sel = 1'b1; bus_write_en = 1'b1; bus_addr = a; bus_write_data = d;
    @(posedge clk); #1;
    if (in_rng(a)) begin
      model[widx(a)] = d;
      m_wr++;
    end
    $display("write addr=%h data=%h", a, d);
    chk("wr_err", 64'(err_pulse), 64'(!in_rng(a)));
  endtask

  task automatic wait_valid(output int vc);
    bit seen = 1'b0;
    for (int i = 0; i < RL + 4 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus_read_valid) seen = 1'b1;
      else chk("err_clear", 64'(err_pulse), 64'd0);
    end
    if (!seen) chk("rd_timeout", 64'd0, 64'd1);
    vc = cyc;
  endtask

  task automatic bus_read(input logic [63:0] a, output int vc);
    logic [63:0] e;
    e = in_rng(a) ? model[widx(a)] : ERRW;
    bus_sel = 1'b1; bus_write_en = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    sb.push_back('{data: e, due: cyc + RL});
    n_reads++; m_rd++;
    chk("rd_err", 64'(err_pulse), 64'(!in_rng(a)));
    wait_valid(vc);
  endtask

  task automatic chk_stats(input string tag);
`ifdef PIM_BUS_TARGET_STATS_EN
    chk({tag, "_rd"}, 64'(rd_count), 64'(m_rd));
    chk({tag, "_wr"}, 64'(wr_count), 64'(m_wr));
`else
    chk({tag, "_rd"}, 64'(rd_count), 64'd0);
    chk({tag, "_wr"}, 64'(wr_count), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          vc, prev;
    logic [63:0] old, e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus_read_valid), 64'd0);
    chk("rst_data", bus_read_data, 64'd0);
    chk("rst_err", 64'(err_pulse), 64'd0);
    chk("rst_core_valid", 64'(core_rd_valid), 64'd0);
    chk("rst_core_data", core_rd_data, 64'd0);
    chk_stats("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write then read with held request.
    bus_write(BASE + 64'h8, 64'h1111_2222_3333_4444); idle();
    bus_read(BASE + 64'h8, vc); idle();
    @(posedge clk); #1;
    chk("hold_data", bus_read_data, 64'h1111_2222_3333_4444);
    chk("hold_valid", 64'(bus_read_valid), 64'd0);

    // Back-to-back writes, then a stalled read burst.
    for (int i = 0; i < 4; i++) bus_write(BASE + 64'(i * 8), 64'(i + 1));
    idle();
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 64'(i * 8), vc);
      if (i > 0) chk("burst_gap", 64'(vc - prev), 64'(RL + 1));
      prev = vc;
    end
    idle();

    // Out of range read and write; word 0 must be untouched.
    bus_read(BASE + 64'(DEPTH * 8), vc); idle();
    bus_write(BASE + 64'(DEPTH * 8), 64'h55); idle();
    @(posedge clk); #1;
    chk("err_one_cycle", 64'(err_pulse), 64'd0);
    bus_read(BASE, vc); idle();

    // Unaligned read lands on word 1.
    bus_read(BASE + 64'hC, vc); idle();

    // Core read colliding with a bus write to the same word.
    old = model[3];
    core_rd_en = 1'b1; core_rd_addr = 8'd3;
    bus_write(BASE + 64'h18, 64'hA5A5_0000_5A5A_FFFF);
    chk("core_valid", 64'(core_rd_valid), 64'd1);
    chk("core_old", core_rd_data, old);
    idle();
    @(posedge clk); #1;
    chk("core_new", core_rd_data, 64'hA5A5_0000_5A5A_FFFF);
    core_rd_en = 1'b0;
    @(posedge clk); #1;
    chk("core_valid_low", 64'(core_rd_valid), 64'd0);

    // Write beat during READ_WAIT is dropped and flagged.
    e = model[2];
    bus_sel = 1'b1; bus_write_en = 1'b0; bus_addr = BASE + 64'h10;
    @(posedge clk); #1;
    sb.push_back('{data: e, due: cyc + RL});
    n_reads++; m_rd++;
    bus_write_en = 1'b1; bus_write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    chk("viol_err", 64'(err_pulse), 64'd1);
    bus_write_en = 1'b0;
    wait_valid(vc); idle();
    bus_read(BASE + 64'h10, vc); idle();
    chk_stats("stats");

    // Reset in the middle of a read aborts it.
    bus_sel = 1'b1; bus_write_en = 1'b0; bus_addr = BASE + 64'h8;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    m_rd = 0; m_wr = 0;
    chk("mid_rst_valid", 64'(bus_read_valid), 64'd0);
    chk("mid_rst_data", bus_read_data, 64'd0);
    chk("mid_rst_err", 64'(err_pulse), 64'd0);
    chk_stats("mid_rst");
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_valid", 64'(bus_read_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(bus_read_valid), 64'd0);
    bus_read(BASE + 64'h8, vc); idle();
    chk_stats("post_rst");
    @(posedge clk); #1;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("pulse_count", 64'(n_pulses), 64'(n_reads));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
